// File: rtl/dbg_imem_reader_if.sv
// Bundle of request, instruction-memory and response signals for dbg_imem_reader.
// The master modport is the reader; the slave modport is its environment.
interface dbg_imem_reader_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [7:0]      req_len;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] rsp_addr;
  logic            rsp_last;
  logic            busy;
  logic            err_misalign;

  modport master (
    input  req_valid, req_addr, req_len, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_last,
           busy, err_misalign
  );

  modport slave (
    output req_valid, req_addr, req_len, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_last,
           busy, err_misalign
  );
endinterface

// File: rtl/dbg_imem_reader.sv
// Debug burst reader: fetches a run of instruction words from a 1-cycle-latency
// memory into a small response FIFO, never issuing a read the FIFO cannot absorb.
module dbg_imem_reader #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  dbg_imem_reader_if.master   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [8:0]      remain_reg, remain_next;
  logic [XLEN-1:0] mem_addr_reg;
  logic            flight_reg;
  logic            flight_last_reg;
  logic [XLEN-1:0] flight_addr_reg;
  logic            err_reg;

  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [XLEN-1:0] addr_mem [FIFO_DEPTH];
  logic            last_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;

  logic            accept, aligned, issue, issue_last, push, pop, pop_last, fifo_ne;
  logic [AW:0]     free_slots;

  assign accept     = bus.req_valid && (state_reg == IDLE);
  assign aligned    = (bus.req_addr[1:0] == 2'b00);
  assign fifo_ne    = (count_reg != '0);
  // Free slots come from the registered count, so a pop this cycle only helps the next issue.
  assign free_slots = (AW+1)'(FIFO_DEPTH) - count_reg;
  assign issue      = (state_reg == READ) && (remain_reg != 9'd0)
                      && (free_slots > {{AW{1'b0}}, flight_reg});
  assign issue_last = issue && (remain_reg == 9'd1);
  assign push       = flight_reg;
  assign pop        = fifo_ne && bus.rsp_ready;
  assign pop_last   = pop && last_mem[rd_ptr_reg];

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    case (state_reg)
      IDLE: begin
        if (accept && aligned) begin
          addr_next   = bus.req_addr;
          remain_next = {1'b0, bus.req_len} + 9'd1;
          state_next  = READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_next   = addr_reg + XLEN'(4);
          remain_next = remain_reg - 9'd1;
          if (issue_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remain_reg      <= '0;
      mem_addr_reg    <= '0;
      flight_reg      <= 1'b0;
      flight_last_reg <= 1'b0;
      flight_addr_reg <= '0;
      err_reg         <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remain_reg      <= remain_next;
      if (issue) mem_addr_reg <= addr_reg;
      flight_reg      <= issue;
      flight_last_reg <= issue_last;
      flight_addr_reg <= addr_reg;
      err_reg         <= accept && !aligned;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg       <= count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage is not reset; the count gates every output read.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.mem_rdata;
      addr_mem[wr_ptr_reg] <= flight_addr_reg;
      last_mem[wr_ptr_reg] <= flight_last_reg;
    end
  end

  assign bus.req_ready    = (state_reg == IDLE);
  assign bus.mem_rd_en    = issue;
  assign bus.mem_addr     = issue ? addr_reg : mem_addr_reg;
  assign bus.rsp_valid    = fifo_ne;
  assign bus.rsp_data     = fifo_ne ? data_mem[rd_ptr_reg] : '0;
  assign bus.rsp_addr     = fifo_ne ? addr_mem[rd_ptr_reg] : '0;
  assign bus.rsp_last     = fifo_ne && last_mem[rd_ptr_reg];
  assign bus.busy         = (state_reg != IDLE);
  assign bus.err_misalign = err_reg;
endmodule

// File: tb/tb_dbg_imem_reader.sv
// Randomized bench for dbg_imem_reader: a memory model plus a burst-level scoreboard
// derived from request parameters, with directed boundary scenarios.
module tb_dbg_imem_reader;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbg_imem_reader_if #(.XLEN(XLEN)) bus ();

  dbg_imem_reader #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } rsp_t;

  rsp_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  int          rd_cnt = 0;
  int          pops = 0;
  logic [31:0] last_mem_addr = '0;
  logic        hold_valid = 1'b0;
  rsp_t        hold;
  logic        rdy_rand = 1'b0;
  logic        rdy_fixed = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h00C0016F;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory with exactly one cycle of read latency; junk when not read.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem_word(bus.mem_addr) : $urandom();

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      last_mem_addr = '0;
      hold_valid    = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        rd_cnt++;
        last_mem_addr = bus.mem_addr;
      end else begin
        chk("mem_addr_hold", bus.mem_addr, last_mem_addr);
      end
      if (hold_valid) begin
        chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
        chk("stall_data", bus.rsp_data, hold.d);
        chk("stall_addr", bus.rsp_addr, hold.a);
        chk("stall_last", 32'(bus.rsp_last), 32'(hold.l));
      end
      if (expq.size() == 0) begin
        chk("no_rsp_expected", 32'(bus.rsp_valid), 32'd0);
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_t e;
        e = expq.pop_front();
        chk("rsp_data", bus.rsp_data, e.d);
        chk("rsp_addr", bus.rsp_addr, e.a);
        chk("rsp_last", 32'(bus.rsp_last), 32'(e.l));
        pops++;
      end
      hold_valid = bus.rsp_valid && !bus.rsp_ready;
      hold.a = bus.rsp_addr;
      hold.d = bus.rsp_data;
      hold.l = bus.rsp_last;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_addr", bus.rsp_addr, 32'd0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_misalign), 32'd0);
  endtask

  // Returns one ns after the accepting edge; expected words are queued from the request alone.
  task automatic send_req(input logic [31:0] a, input logic [7:0] l);
    int n;
    logic [31:0] wa;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    n = 0;
    while (!bus.req_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (a[1:0] == 2'b00) begin
      for (int i = 0; i <= int'(l); i++) begin
        rsp_t e;
        wa  = a + 32'(4 * i);
        e.a = wa;
        e.d = mem_word(wa);
        e.l = (i == int'(l));
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("err_misalign", 32'(bus.err_misalign), 32'(a[1:0] != 2'b00));
    $display("[TB] req addr=%h len=%0d", a, l);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((expq.size() != 0 || bus.busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_queue", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int rd0, p0, n;
    logic [31:0] a;
    logic [7:0]  l;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();

    // Single word with latency and busy timing.
    send_req(32'h4, 8'd0);
    chk("lat_e0_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_e1_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_e2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_data", bus.rsp_data, 32'h00C0016F);
    chk("single_addr", bus.rsp_addr, 32'h4);
    chk("single_last", 32'(bus.rsp_last), 32'd1);
    @(posedge clk); #1;
    chk("single_busy_after", 32'(bus.busy), 32'd0);
    chk("single_valid_after", 32'(bus.rsp_valid), 32'd0);
    wait_idle();

    // Eight-word burst at full throughput.
    p0 = pops;
    send_req(32'h0, 8'd7);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("burst_tput", 32'(bus.rsp_valid), 32'd1);
    end
    wait_idle();
    chk("burst_count", 32'(pops - p0), 32'd8);

    // Backpressure: only DEPTH reads may be outstanding.
    rdy_fixed = 1'b0;
    rd0 = rd_cnt;
    p0  = pops;
    send_req(32'h10, 8'd9);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_reads", 32'(rd_cnt - rd0), 32'(DEPTH));
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    rdy_fixed = 1'b1;
    wait_idle();
    chk("bp_count", 32'(pops - p0), 32'd10);

    // Address wrap.
    send_req(32'hFFFFFFF8, 8'd3);
    wait_idle();

    // Misaligned request is rejected.
    rd0 = rd_cnt;
    send_req(32'h6, 8'd2);
    chk("mis_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("mis_err_pulse_end", 32'(bus.err_misalign), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("mis_no_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("mis_busy", 32'(bus.busy), 32'd0);

    // Reset while the fifth response is presented.
    p0 = pops;
    send_req(32'h0, 8'd15);
    n = 0;
    while ((pops - p0) < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_pops_before_rst", 32'(pops - p0), 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", 32'(bus.rsp_valid), 32'd0);
    end

    // Random bursts with random backpressure.
    rdy_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      a = $urandom();
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFF0 | (a & 32'h3);
      l = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      send_req(a, l);
      wait_idle();
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbg_imem_reader.md
DBG_IMEM_READER -- requirements
Module: dbg_imem_reader

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, response FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  burst read request.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_addr  input  XLEN  start byte address, word-aligned.
REQ-008 SHALL have port req_len  input  8  word count minus one (0 -> 1 word, 255 -> 256 words).
REQ-009 SHALL have port mem_rd_en  output  1  instruction-memory read strobe.
REQ-010 SHALL have port mem_addr  output  XLEN  instruction-memory byte address.
REQ-011 SHALL have port mem_rdata  input  XLEN  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port rsp_valid  output  1  response word available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 SHALL have port rsp_data  output  XLEN  instruction word read.
REQ-015 SHALL have port rsp_addr  output  XLEN  byte address of rsp_data.
REQ-016 SHALL have port rsp_last  output  1  final word of burst.
REQ-017 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-018 SHALL have port err_misalign  output  1  one-cycle pulse on rejected misaligned request.

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-020 SHALL assert req_ready only in IDLE.
REQ-021 On acceptance with req_addr[1:0]==0: SHALL latch address and remaining count (req_len+1), go to READ next cycle.
REQ-022 On acceptance with req_addr[1:0]!=0: SHALL pulse err_misalign the next cycle, issue no reads, remain IDLE.
REQ-023 In READ, SHALL assert mem_rd_en only when FIFO free entries exceed in-flight reads (0 or 1); no read shall ever overflow the FIFO.
REQ-024 Each issued read SHALL decrement remaining count and advance mem_addr by 4, wrapping modulo 2^XLEN.
REQ-025 SHALL push mem_rdata, its address and last flag into FIFO the cycle after mem_rd_en.
REQ-026 Last flag SHALL be set on the read issued with remaining count == 1.
REQ-027 After issuing the last read, SHALL go to DRAIN; DRAIN -> IDLE on the cycle the rsp_last word is popped.
REQ-028 Back-to-back throughput SHALL be one word per cycle when rsp_ready held high; first rsp_valid 2 cycles after acceptance.
REQ-029 rsp_valid SHALL be high iff FIFO non-empty; rsp_data/addr/last SHALL be stable while rsp_valid && !rsp_ready.
REQ-030 Simultaneous FIFO push and pop SHALL keep occupancy constant, including when full (pop frees slot same cycle only for next issue decision).
REQ-031 mem_addr SHALL hold its last value when mem_rd_en is low.

Reset
REQ-032 On rst, next cycle: state IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, busy=0, err_misalign=0.
REQ-033 rst mid-burst SHALL flush FIFO and discard any in-flight mem_rdata; no response from the aborted burst shall appear after reset.
REQ-034 rst SHALL take priority over a simultaneous request.

Verification
REQ-035 Single word: addr=0x4, len=0, memory[0x4]=0x00C0016F, rsp_ready=1 -> one response data=0x00C0016F, addr=0x4, last=1, 2 cycles after acceptance; busy low next cycle after pop.
REQ-036 Burst: addr=0x0, len=7, rsp_ready=1 -> 8 responses addr 0x0..0x1C, one per cycle, last only on 0x1C.
REQ-037 Backpressure: addr=0x10, len=9, rsp_ready low 20 cycles -> exactly FIFO_DEPTH reads issued, output stable; on release all 10 words delivered in order, no loss/duplication.
REQ-038 Wrap: addr=0xFFFFFFF8, len=3 -> response addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-039 Misaligned: addr=0x6, len=2 -> err_misalign pulses 1 cycle, mem_rd_en never asserted, req_ready stays high.
REQ-040 Reset mid-burst: addr=0x0, len=15, rst at 5th response for 1 cycle -> all outputs at reset values next cycle, no further rsp_valid until new request.
